// File: rtl/ext_pkg.sv
// Shared definitions for the custom-opcode extension unit.
// Holds the operation select encoding (funct3), the control FSM states and
// the custom opcode value that the decode controller also matches on.
package ext_pkg;

  localparam logic [4:0] EXT_OPCODE = 5'b11011;

  // funct3 operation select
  typedef enum logic [2:0] {
    EXT_MULL  = 3'd0,
    EXT_MULHU = 3'd1,
    EXT_DIVU  = 3'd2,
    EXT_REMU  = 3'd3,
    EXT_CPOP  = 3'd4,
    EXT_CLZ   = 3'd5,
    EXT_ROL   = 3'd6,
    EXT_RSVD  = 3'd7
  } ext_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ext_state_e;

  // Multiply and divide ops run on the radix-2 step engine
  function automatic logic is_iterative(ext_op_e op);
    return (op == EXT_MULL) || (op == EXT_MULHU) ||
           (op == EXT_DIVU) || (op == EXT_REMU);
  endfunction

endpackage

// File: rtl/ext_iter_datapath.sv
// Radix-2 multiply/divide step engine with one shared adder/subtractor.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start_i          load operands for a new operation (sel_i, a_i, b_i)
//   step_i           perform one iteration
//   sel_i            MULL / MULHU / DIVU / REMU
//   a_i, b_i         operands A and B
//   result_c_o       value the selected result will hold after this step
//   done_c_o         this step is the last one (counter at XLEN-1)
module ext_iter_datapath
  import ext_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  ext_op_e         sel_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_c_o,
  output logic            done_c_o
);

  // hi/lo form the 2*XLEN multiply accumulator; for divide hi is the
  // remainder and lo shifts the dividend out while the quotient shifts in.
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic             is_div_q, is_div_d, hi_sel_q, hi_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    part_rem, mul_sum;
  logic [XLEN+1:0]  add_a, add_b, sum;

  // Shared adder: hi + A for multiply, partial remainder - B for divide
  always_comb begin
    part_rem = {hi_q, lo_q[XLEN-1]};
    add_a    = is_div_q ? {1'b0, part_rem} : {2'b00, hi_q};
    add_b    = {2'b00, opnd_q} ^ {(XLEN+2){is_div_q}};
    sum      = add_a + add_b + (XLEN+2)'(is_div_q);
  end

  // Step sequencing
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    hi_sel_d = hi_sel_q;
    cnt_d    = cnt_q;
    mul_sum  = {1'b0, hi_q};
    if (start_i) begin
      is_div_d = (sel_i == EXT_DIVU) || (sel_i == EXT_REMU);
      hi_sel_d = (sel_i == EXT_MULHU) || (sel_i == EXT_REMU);
      hi_d     = '0;
      lo_d     = is_div_d ? a_i : b_i;
      opnd_d   = is_div_d ? b_i : a_i;
      cnt_d    = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div_q) begin
        // Restoring: keep the difference only when it did not go negative
        lo_d = {lo_q[XLEN-2:0], ~sum[XLEN+1]};
        hi_d = sum[XLEN+1] ? part_rem[XLEN-1:0] : sum[XLEN-1:0];
      end else begin
        if (lo_q[0]) mul_sum = sum[XLEN:0];
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign done_c_o   = (cnt_q == CNT_W'(XLEN - 1));
  assign result_c_o = hi_sel_q ? hi_d : lo_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      hi_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      hi_sel_q <= hi_sel_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/extension_unit.sv
// Execution unit for the custom opcode: multiply/divide (iterative) and
// CPOP/CLZ/ROL (single-cycle), with request/response handshakes.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   flush                       abort any in-flight operation
//   req_valid/req_ready         request handshake
//   req_sel, req_rs1, req_rs2   funct3 select and operands
//   req_rd                      destination tag
//   resp_valid/resp_ready       response handshake
//   resp_data, resp_rd          result and echoed tag
//   resp_illegal                reserved select was used
//   busy                        operation in flight or result pending
module extension_unit
  import ext_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_sel,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_illegal,
  output logic            busy
);

  ext_state_e       state_q, state_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [4:0]       rd_q, rd_d;
  logic             ill_q, ill_d;
  logic             valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;

  ext_op_e          op;
  logic             dp_start, dp_step, dp_done;
  logic [XLEN-1:0]  dp_result;
  logic [CNT_W:0]   pop, clz;
  logic [CNT_W-1:0] shamt, rshamt;
  logic [XLEN-1:0]  rol, single_res;

  assign op = ext_op_e'(req_sel);

  ext_iter_datapath #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (dp_start),
    .step_i     (dp_step),
    .sel_i      (op),
    .a_i        (req_rs1),
    .b_i        (req_rs2),
    .result_c_o (dp_result),
    .done_c_o   (dp_done)
  );

  // Single-cycle operations on the raw request operands
  always_comb begin
    pop = '0;
    clz = (CNT_W+1)'(XLEN);
    for (int i = 0; i < int'(XLEN); i++) begin
      pop = pop + (CNT_W+1)'(req_rs1[i]);
      if (req_rs1[i]) clz = (CNT_W+1)'(int'(XLEN) - 1 - i);
    end
    // XLEN is a power of two, so XLEN - shamt wraps to -shamt in CNT_W bits
    shamt  = req_rs2[CNT_W-1:0];
    rshamt = CNT_W'(0) - shamt;
    rol    = (shamt == '0) ? req_rs1 : ((req_rs1 << shamt) | (req_rs1 >> rshamt));
    case (op)
      EXT_CPOP: single_res = XLEN'(pop);
      EXT_CLZ:  single_res = XLEN'(clz);
      EXT_ROL:  single_res = rol;
      default:  single_res = '0;
    endcase
  end

  // Control FSM; flush overrides every other input
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rd_d     = rd_q;
    ill_d    = ill_q;
    dp_start = 1'b0;
    dp_step  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rd_d  = req_rd;
            ill_d = (op == EXT_RSVD);
            if (is_iterative(op)) begin
              dp_start = 1'b1;
              state_d  = BUSY;
            end else begin
              data_d  = single_res;
              state_d = DONE;
            end
          end
        end
        BUSY: begin
          dp_step = 1'b1;
          if (dp_done) begin
            data_d  = dp_result;
            state_d = DONE;
          end
        end
        DONE: begin
          if (resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready    = ready_q;
  assign resp_valid   = valid_q;
  assign resp_data    = data_q;
  assign resp_rd      = rd_q;
  assign resp_illegal = ill_q;
  assign busy         = busy_q;

endmodule

// File: doc/extension_unit.md
Name: extension_unit

Overview:
- Execution end of the custom-opcode (5'b11011) path. The decode stage selects an operation with funct3 and stalls PC writes while this block computes.
- Accepts one request (select, two operands, destination register tag) through a valid/ready handshake.
- Runs the selected operation in 1 or XLEN+1 cycles and returns the result on a response handshake for register writeback.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; synchronous, active-low.
- flush  input  1  abort in-flight operation (branch/trap).
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_sel  input  3  operation select (funct3).
- req_rs1  input  XLEN  operand A.
- req_rs2  input  XLEN  operand B.
- req_rd  input  5  destination register tag.
- resp_valid  output  1  result available.
- resp_ready  input  1  writeback consumes result.
- resp_data  output  XLEN  result.
- resp_rd  output  5  tag echoed from the request.
- resp_illegal  output  1  request used a reserved select.
- busy  output  1  high in BUSY or DONE; core holds pcWE low while busy.

Behaviour:
- Operations (req_sel):
  - 0 MULL: low XLEN bits of A*B, iterative.
  - 1 MULHU: high XLEN bits of unsigned A*B, iterative.
  - 2 DIVU: unsigned quotient, iterative.
  - 3 REMU: unsigned remainder, iterative.
  - 4 CPOP: population count of A, single-cycle.
  - 5 CLZ: leading zeros of A, single-cycle; A=0 gives XLEN.
  - 6 ROL: A rotated left by B[CNT_W-1:0], single-cycle.
  - 7 reserved: resp_data=0, resp_illegal=1, single-cycle.
- States:
  - IDLE: req_ready=1. On req_valid, capture operands, sel and rd. Iterative ops go to BUSY with cnt=0; others compute into the result register and go to DONE.
  - BUSY: req_ready=0. One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. cnt increments each cycle. At cnt==XLEN-1 the step completes and the state goes to DONE.
  - DONE: resp_valid=1 and resp_data/resp_rd/resp_illegal held stable until resp_ready. On resp_valid&resp_ready, return to IDLE.
  - No new request is accepted in the same cycle as a response handshake. req_ready is asserted only in IDLE.
- Latency, with the accept edge at cycle N:
  - Single-cycle ops: resp_valid high from N+1.
  - Iterative ops: resp_valid high from N+XLEN+1.
- Arithmetic:
  - Multiply uses a 2*XLEN accumulator. MULL takes the low half, MULHU the high half.
  - Divide uses an XLEN+1-bit partial remainder.
  - Divide by zero: DIVU result = all ones, REMU result = A. No trap, still XLEN+1 cycles.
  - ROL with a shift of 0 returns A unchanged.
- flush:
  - Any state goes to IDLE the next cycle, the result is discarded, and resp_valid is never raised for that request.
  - flush takes priority over req_valid and resp_ready in the same cycle.
  - A request presented together with flush is not accepted.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, cnt=0.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_illegal=0, busy=0.
  - req_ready=0 during reset, 1 in the first cycle after release.
  - Reset mid-operation behaves like flush.
- req_* inputs are ignored outside IDLE. Operands are registered, so they may change after acceptance.

Decomposition:
- Shared package ext_pkg:
  - enum ext_op_e (EXT_MULL..EXT_RSVD, 3 bits);
  - enum ext_state_e (IDLE, BUSY, DONE);
  - constant EXT_OPCODE = 5'b11011, shared with the decode controller.
- One sub-module, ext_iter_datapath: multiply/divide step engine with a shared adder/subtractor. Inputs: start, sel, A, B. Outputs: step result and done.
- The FSM and the single-cycle ops stay in extension_unit.

Test Plan:
- Reset mid-BUSY: MULL 5*7, assert rst_n=0 at cycle N+10 -> the next cycle all outputs are 0, req_ready=1 one cycle after release, no response ever appears.
- MULL/MULHU: A=0xFFFF_FFFF, B=0x0000_0002 with resp_ready=1 -> MULL gives 0xFFFF_FFFE and MULHU gives 0x0000_0001. resp_valid first rises exactly 33 cycles after accept, resp_rd echoes rd=13.
- DIVU/REMU: A=100, B=7 -> 14 and 2. A=0x1234, B=0 -> DIVU 0xFFFF_FFFF, REMU 0x1234.
- Single-cycle ops: CPOP A=0xF0F0_0001 -> 9; CLZ A=0 -> 32; CLZ A=0x0001_0000 -> 15; ROL A=0x8000_0001, B=1 -> 0x0000_0003. All give resp_valid at N+1. sel=7 gives data 0 and resp_illegal=1.
- Backpressure: resp_ready held low for 5 cycles in DONE -> resp_data stable, req_ready=0, a new req_valid is not accepted. The response handshake completes on the 6th cycle, and the next request is accepted one cycle later.
- Flush: DIVU started, flush at cycle N+10 -> IDLE at N+11, resp_valid never rises. A new request accepted at N+11 completes with the correct value.
